// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Shared types and constants for the unified instruction/data memory
//   arbiter of the pipelined RISC-V core.
//   arb_state_t : arbiter FSM state (IDLE, BUSY, RESP)
//   owner_t     : which requester owns the command in flight
//   BE_ALL      : all-ones byte-enable constant, sliced to the port width
//                 by users (wide enough for data widths up to 1024 bits)
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Shares one memory port between instruction fetch (IF) and load/store
//   (D). Data wins by default; after MAX_WAIT consecutive data grants with
//   fetch pending, fetch is forced to win. The winning command is registered
//   onto mem_*, held until mem_ready, and the response is returned to the
//   owner as a one-cycle rvalid pulse.
//
//   Handshakes: a requester holds req and its payload until gnt, a one-cycle
//   pulse meaning the command was taken (it may drop req before gnt). On the
//   memory side mem_req is a valid that stays high with mem_* stable until the
//   cycle mem_ready is sampled high; mem_ready is ignored when mem_req is low.
//
//   Ports
//     clk, rst_n                     clock, async active-low reset
//     if_req/if_addr -> if_gnt        fetch request and acceptance pulse
//     if_rvalid/if_rdata              fetch response
//     d_req/d_we/d_addr/d_wdata/d_be  data request payload
//     d_gnt, d_rvalid/d_rdata         data acceptance and response
//     mem_req/mem_we/mem_addr/
//       mem_wdata/mem_be              registered memory command
//     mem_ready/mem_rdata             memory completion and read data
//     stall_if, stall_d               request pending but not granted
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if,
   output logic                stall_d
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   arb_state_t       state, state_nx;
   owner_t           owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             arb_open;
   logic             pick_if;
   logic             mem_done;

   // Arbitration is open in IDLE and RESP. rst_n gates it so no grant can
   // leak out while reset is held with requests pending.
   always_comb begin
      arb_open = rst_n && (state != BUSY);
      pick_if  = if_req && (!d_req || (starve_cnt == CNT_MAX));
      if_gnt   = arb_open && pick_if;
      d_gnt    = arb_open && d_req && !pick_if;
      stall_if = if_req && !if_gnt;
      stall_d  = d_req && !d_gnt;
      mem_done = (state == BUSY) && mem_ready;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, RESP: state_nx = (if_gnt || d_gnt) ? BUSY : IDLE;
         BUSY:       state_nx = mem_ready ? RESP : BUSY;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   assign mem_req   = (state == BUSY);
   assign if_rvalid = (state == RESP) && (owner == OWN_IF);
   assign d_rvalid  = (state == RESP) && (owner == OWN_D);

   // Command register: loaded only on a grant, so it is stable through BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= OWN_IF;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else if (if_gnt) begin
         owner     <= OWN_IF;
         mem_we    <= 1'b0;
         mem_addr  <= if_addr;
         mem_wdata <= '0;
         mem_be    <= BE_ALL[DATA_W/8-1:0];
      end else if (d_gnt) begin
         owner     <= OWN_D;
         mem_we    <= d_we;
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
         mem_be    <= d_be;
      end
   end

   // Response registers hold until the next completion for the same owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rdata <= '0;
         d_rdata  <= '0;
      end else if (mem_done) begin
         if (owner == OWN_IF) if_rdata <= mem_rdata;
         else                 d_rdata  <= mem_we ? '0 : mem_rdata;
      end
   end

   // Counts data grants taken while fetch waits; any cycle without a fetch
   // request or with a fetch grant restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              starve_cnt <= '0;
      else if (!if_req || if_gnt)              starve_cnt <= '0;
      else if (d_gnt && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
//   Directed bench for riscv_mem_arbiter: lone fetch, waited store,
//   starvation guard ordering, back-to-back loads, mid-access reset and a
//   fetch request withdrawn before grant.
module tb_riscv_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk, rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [3:0]    d_be;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          stall_if, stall_d;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   // memory responder controls
   int          mem_wait  = 0;
   logic        use_fixed = 1'b0;
   logic [31:0] fixed_data = '0;

   riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_d(stall_d)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: raises mem_ready after mem_wait BUSY cycles; read
   // data is ~addr unless a fixed word is selected.
   initial begin : responder
      int wcnt;
      wcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            if (wcnt == mem_wait) begin
               mem_ready = 1'b1;
               mem_rdata = use_fixed ? fixed_data : ~mem_addr;
               wcnt      = 0;
            end else begin
               mem_ready = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      if_req  = 1'b0; if_addr = '0;
      d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
   endtask

   initial begin : main
      logic [31:0] ld_addr [3];
      int          ngnt;
      ld_addr[0] = 32'h40; ld_addr[1] = 32'h44; ld_addr[2] = 32'h48;

      // reset
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) tick();
      check("rst_mem_req",   32'(mem_req), 0);
      check("rst_gnt",       32'({if_gnt, d_gnt}), 0);
      check("rst_rvalid",    32'({if_rvalid, d_rvalid}), 0);
      check("rst_mem_addr",  mem_addr, 0);
      check("rst_mem_be",    32'(mem_be), 0);
      check("rst_rdata",     if_rdata | d_rdata, 0);
      rst_n = 1'b1;
      tick();

      // lone fetch
      use_fixed = 1'b1; fixed_data = 32'h0050_0093; mem_wait = 0;
      if_req = 1'b1; if_addr = 32'h100;
      settle();
      check("f_if_gnt", 32'(if_gnt), 1);
      check("f_d_gnt",  32'(d_gnt), 0);
      check("f_stall",  32'(stall_if), 0);
      tick();
      if_req = 1'b0;
      settle();
      check("f_mem_req",  32'(mem_req), 1);
      check("f_mem_addr", mem_addr, 32'h100);
      check("f_mem_we",   32'(mem_we), 0);
      check("f_mem_be",   32'(mem_be), 32'hF);
      check("f_mem_wd",   mem_wdata, 0);
      tick();
      settle();
      check("f_if_rvalid", 32'(if_rvalid), 1);
      check("f_if_rdata",  if_rdata, 32'h0050_0093);
      check("f_d_rvalid",  32'(d_rvalid), 0);
      tick();
      settle();
      check("f_rvalid_pulse", 32'(if_rvalid), 0);
      check("f_rdata_hold",   if_rdata, 32'h0050_0093);

      // store with three wait cycles
      use_fixed = 1'b0; mem_wait = 3;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
      settle();
      check("st_d_gnt", 32'(d_gnt), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         d_req = 1'b0;
         settle();
         check("st_mem_req",  32'(mem_req), 1);
         check("st_mem_addr", mem_addr, 32'h2000);
         check("st_mem_wd",   mem_wdata, 32'hDEAD_BEEF);
         check("st_mem_be",   32'(mem_be), 32'h3);
         check("st_mem_we",   32'(mem_we), 1);
         check("st_no_rvalid", 32'(d_rvalid), 0);
      end
      tick();
      settle();
      check("st_d_rvalid", 32'(d_rvalid), 1);
      check("st_d_rdata",  d_rdata, 0);
      check("st_mem_req_drop", 32'(mem_req), 0);
      tick();
      settle();
      check("st_rvalid_pulse", 32'(d_rvalid), 0);

      // continuous fetch + data: starvation guard order (1 = data, 0 = fetch)
      mem_wait = 0;
      exp_q = '{1, 1, 1, 0, 1, 1, 1, 0};
      d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF; d_wdata = '0;
      if_addr = 32'h104;
      if_req = 1'b1; d_req = 1'b1;
      ngnt = 0;
      for (int c = 0; c < 16; c++) begin
         settle();
         check("arb_both_gnt", 32'(if_gnt & d_gnt), 0);
         if (if_gnt || d_gnt) begin
            ngnt++;
            if (exp_q.size() == 0) check("arb_extra_gnt", 32'(ngnt), 8);
            else                   check("arb_order", 32'(d_gnt), exp_q.pop_front());
         end
         if (d_rvalid)  check("arb_d_rdata",  d_rdata,  32'hFFFF_CFFF);
         if (if_rvalid) check("arb_if_rdata", if_rdata, 32'hFFFF_FEFB);
         tick();
      end
      check("arb_gnt_count", 32'(ngnt), 8);
      check("arb_q_empty",   32'(exp_q.size()), 0);
      idle_inputs();
      tick();
      tick();

      // back-to-back zero-wait loads
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         d_addr = ld_addr[k];
         settle();
         check("bb_d_gnt", 32'(d_gnt), 1);
         if (k > 0) begin
            check("bb_rvalid_with_gnt", 32'(d_rvalid), 1);
            check("bb_rdata", d_rdata, exp_q.pop_front());
         end
         case (k)
            0: exp_q.push_back(32'hFFFF_FFBF);
            1: exp_q.push_back(32'hFFFF_FFBB);
            default: exp_q.push_back(32'hFFFF_FFB7);
         endcase
         tick();
         if (k == 2) d_req = 1'b0;
         settle();
         check("bb_busy_no_gnt", 32'(d_gnt), 0);
         check("bb_mem_addr", mem_addr, ld_addr[k]);
         tick();
      end
      settle();
      check("bb_last_rvalid", 32'(d_rvalid), 1);
      check("bb_last_rdata",  d_rdata, exp_q.pop_front());
      tick();

      // reset during BUSY
      mem_wait = 10;
      d_req = 1'b1; d_addr = 32'h50;
      settle();
      check("rb_d_gnt", 32'(d_gnt), 1);
      tick();
      d_req = 1'b0;
      settle();
      check("rb_mem_req", 32'(mem_req), 1);
      rst_n = 1'b0;
      #1;
      check("rb_async_drop", 32'(mem_req), 0);
      check("rb_no_rvalid",  32'({if_rvalid, d_rvalid}), 0);
      tick();
      rst_n = 1'b1;
      settle();
      check("rb_mem_addr_rst", mem_addr, 0);
      check("rb_starve_rst",   32'(dut.starve_cnt), 0);
      tick();
      settle();
      check("rb_still_no_rvalid", 32'({if_rvalid, d_rvalid}), 0);
      mem_wait = 0; use_fixed = 1'b1; fixed_data = 32'h0000_0013;
      if_req = 1'b1; if_addr = 32'h200;
      settle();
      check("rb_if_gnt", 32'(if_gnt), 1);
      tick();
      if_req = 1'b0;
      settle();
      check("rb_mem_addr", mem_addr, 32'h200);
      tick();
      settle();
      check("rb_if_rvalid", 32'(if_rvalid), 1);
      check("rb_if_rdata",  if_rdata, 32'h0000_0013);
      tick();

      // fetch withdrawn before grant while data wins
      use_fixed = 1'b0;
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
      settle();
      check("wd_d_gnt",    32'(d_gnt), 1);
      check("wd_if_gnt",   32'(if_gnt), 0);
      check("wd_stall_if", 32'(stall_if), 1);
      check("wd_stall_d",  32'(stall_d), 0);
      tick();
      d_req = 1'b0;
      settle();
      check("wd_busy_stall_if", 32'(stall_if), 1);
      check("wd_mem_addr",      mem_addr, 32'h60);
      tick();
      if_req = 1'b0;
      settle();
      check("wd_d_rvalid",   32'(d_rvalid), 1);
      check("wd_no_if_gnt",  32'(if_gnt), 0);
      check("wd_stall_drop", 32'(stall_if), 0);
      tick();
      settle();
      check("wd_idle_mem_req", 32'(mem_req), 0);
      tick();
      settle();
      check("wd_no_fetch_cmd", 32'(mem_req), 0);
      check("wd_addr_kept",    mem_addr, 32'h60);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
